// File: rtl/wide_add_sequencer.sv
// Multi-byte add/subtract sequencer feeding an external 8-bit adder one byte pair per cycle,
// least significant byte first, and returning the wide result over a valid/ready handshake.
module wide_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                cin,
  input  logic                sub,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_sum,
  input  logic                add_cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out,
  output logic                overflow
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]             state;
  logic [IDX_W-1:0]       idx;
  logic                   carry;
  logic                   sub_q;
  logic [NBYTES-1:0][7:0] a_q;
  logic [NBYTES-1:0][7:0] b_q;
  logic [NBYTES-1:0][7:0] res_q;
  logic                   last;

  // Sign overflow: operands agree in sign but the sum's sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = res_q;
  assign last      = (idx == IDX_LAST);

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == ST_RUN) begin
      add_a   = a_q[idx];
      add_b   = sub_q ? ~b_q[idx] : b_q[idx];
      add_cin = carry;
    end
  end

  // Operand capture: pure data, only ever read while in RUN.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      a_q <= op_a;
      b_q <= op_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      sub_q     <= 1'b0;
      res_q     <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sub_q <= sub;
            // Subtraction is A + ~B + 1, with the borrow-in cancelling the +1.
            carry <= cin ^ sub;
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q[idx] <= add_sum;
          carry      <= add_cout;
          if (last) begin
            carry_out <= add_cout;
            overflow  <= signed_ovf(add_a[7], add_b[7], add_sum[7]);
            idx       <= '0;
            state     <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
